rtc_bus_controller: RTL and testbench



---
 rtl/rtc_bus_controller.sv | 211 +++++++++++++++++++++
 tb/tb_rtc_bus_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_controller.sv
// rtc_bus_controller
//   Runs one bus transaction for a multiplexed address/data parallel RTC with
//   Intel-style active-low strobes. A single-cycle command becomes an address
//   phase, followed by a write or read data phase or by nothing (address-only).
//   Every pin, including the bus drive enable, comes straight from a flop, so
//   the strobes cannot glitch.
//
// Ports
//   clk_i      system clock, rising edge
//   reset_i    asynchronous active-high reset
//   start_i    command strobe, sampled only in IDLE
//   op_i       00 write, 01 read, 10 address-only, 11 illegal (err_o pulse)
//   addr_i     register address
//   wdata_i    write data
//   rdata_o    last captured read data
//   busy_o     high from the first cycle after acceptance through DONE
//   done_o     one-cycle pulse in the last busy cycle
//   err_o      one-cycle pulse after a rejected op=11 start
//   ad_o       0 = address phase, 1 = data phase or idle
//   cs_o       active-low chip select
//   wr_o       active-low write strobe
//   rd_o       active-low read strobe
//   bus_io     multiplexed RTC bus, high-Z when not driven
module rtc_bus_controller #(
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 1,
  parameter int T_GAP   = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ad_o,
  output logic              cs_o,
  output logic              wr_o,
  output logic              rd_o,
  inout  wire  [DATA_W-1:0] bus_io
);

  localparam int T_MAX01 = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX23 = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX   = (T_MAX01 > T_MAX23) ? T_MAX01 : T_MAX23;
  // The counter holds (duration - 1), so it needs to reach T_MAX - 1.
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD, S_GAP,
    S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00, OP_READ = 2'b01, OP_ADDR = 2'b10, OP_ILLEGAL = 2'b11
  } op_t;

  typedef struct packed {
    logic              cs;
    logic              ad;
    logic              wr;
    logic              rd;
    logic              drive;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
  } outs_t;

  // Phase length minus one for the state being entered.
  function automatic logic [CNT_W-1:0] reload(input state_t s);
    case (s)
      S_ADDR_SETUP, S_DATA_SETUP: reload = CNT_W'(T_SETUP - 1);
      S_ADDR_PULSE, S_DATA_PULSE: reload = CNT_W'(T_PULSE - 1);
      S_ADDR_HOLD,  S_DATA_HOLD:  reload = CNT_W'(T_HOLD - 1);
      S_GAP:                      reload = CNT_W'(T_GAP - 1);
      default:                    reload = '0;
    endcase
  endfunction

  // Pin values that belong to a state; they are registered on state entry so
  // they line up exactly with the state they describe.
  function automatic outs_t decode(input state_t s, input op_t op,
                                   input logic [DATA_W-1:0] addr,
                                   input logic [DATA_W-1:0] wdata);
    outs_t o;
    o.cs    = 1'b1;
    o.ad    = 1'b1;
    o.wr    = 1'b1;
    o.rd    = 1'b1;
    o.drive = 1'b0;
    o.dout  = '0;
    case (s)
      S_ADDR_SETUP, S_ADDR_PULSE, S_ADDR_HOLD: begin
        o.cs    = 1'b0;
        o.ad    = 1'b0;
        o.drive = 1'b1;
        o.dout  = addr;
        o.wr    = (s != S_ADDR_PULSE);
      end
      S_DATA_SETUP, S_DATA_PULSE, S_DATA_HOLD: begin
        o.cs    = 1'b0;
        // A read never drives, so the RTC owns the bus whenever RD is low.
        o.drive = (op == OP_WRITE);
        o.dout  = wdata;
        o.wr    = !((s == S_DATA_PULSE) && (op == OP_WRITE));
        o.rd    = !((s == S_DATA_PULSE) && (op == OP_READ));
      end
      default: ;
    endcase
    o.busy = (s != S_IDLE);
    o.done = (s == S_DONE);
    return o;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  outs_t             outs_q, outs_d;
  logic              phase_end;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    phase_end = (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (op_t'(op_i) == OP_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ADDR_SETUP;
            op_d    = op_t'(op_i);
            addr_d  = addr_i;
            wdata_d = wdata_i;
          end
        end
      end
      S_ADDR_SETUP: if (phase_end) state_d = S_ADDR_PULSE;
      S_ADDR_PULSE: if (phase_end) state_d = S_ADDR_HOLD;
      S_ADDR_HOLD:  if (phase_end) state_d = (op_q == OP_ADDR) ? S_DONE : S_GAP;
      S_GAP:        if (phase_end) state_d = S_DATA_SETUP;
      S_DATA_SETUP: if (phase_end) state_d = S_DATA_PULSE;
      S_DATA_PULSE: begin
        if (phase_end) begin
          state_d = S_DATA_HOLD;
          // Sampled on the edge that raises RD, while the RTC still drives.
          if (op_q == OP_READ) rdata_d = bus_io;
        end
      end
      S_DATA_HOLD:  if (phase_end) state_d = S_DONE;
      default:      state_d = S_IDLE;  // S_DONE always lasts one cycle
    endcase

    if (state_d != state_q) cnt_d = reload(state_d);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;

    outs_d = decode(state_d, op_d, addr_d, wdata_d);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      outs_q  <= decode(S_IDLE, OP_WRITE, '0, '0);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      outs_q  <= outs_d;
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign busy_o  = outs_q.busy;
  assign done_o  = outs_q.done;
  assign ad_o    = outs_q.ad;
  assign cs_o    = outs_q.cs;
  assign wr_o    = outs_q.wr;
  assign rd_o    = outs_q.rd;
  assign bus_io  = outs_q.drive ? outs_q.dout : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Bench for rtc_bus_controller: a default-parameter instance (u_a) and a
// 16-bit instance with stretched timing (u_b). Stimulus pushes the expected
// outcome of each command into a scoreboard; a monitor watching both
// instances pops and compares on every done/err pulse.
module tb_rtc_bus_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults ----------------
  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [1:0]  op_a = 2'b00;
  logic [7:0]  addr_a = '0, wdata_a = '0, rdata_a;
  logic        busy_a, done_a, err_a, ad_a, cs_a, wr_a, rd_a;
  wire  [7:0]  bus_a;
  logic [7:0]  rtc_a = 8'hC7;
  assign bus_a = rd_a ? {8{1'bz}} : rtc_a;

  rtc_bus_controller u_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .op_i(op_a),
    .addr_i(addr_a), .wdata_i(wdata_a), .rdata_o(rdata_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
    .ad_o(ad_a), .cs_o(cs_a), .wr_o(wr_a), .rd_o(rd_a), .bus_io(bus_a)
  );

  // ---------------- instance B: 16-bit, slow timing ----------------
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [1:0]  op_b = 2'b00;
  logic [15:0] addr_b = '0, wdata_b = '0, rdata_b;
  logic        busy_b, done_b, err_b, ad_b, cs_b, wr_b, rd_b;
  wire  [15:0] bus_b;
  logic [15:0] rtc_b = 16'hBEEF;
  assign bus_b = rd_b ? {16{1'bz}} : rtc_b;

  rtc_bus_controller #(
    .DATA_W(16), .T_SETUP(2), .T_PULSE(6), .T_HOLD(2), .T_GAP(3)
  ) u_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start_b), .op_i(op_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .rdata_o(rdata_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
    .ad_o(ad_b), .cs_o(cs_b), .wr_o(wr_b), .rd_o(rd_b), .bus_io(bus_b)
  );

  // Observation vectors indexed by instance (0 = A, 1 = B).
  logic [1:0]  busy_v, done_v, err_v, ad_v, cs_v, wr_v, rd_v, drv_v;
  logic [15:0] bus_v [2];
  logic [15:0] rdata_v [2];
  assign busy_v = {busy_b, busy_a};
  assign done_v = {done_b, done_a};
  assign err_v  = {err_b, err_a};
  assign ad_v   = {ad_b, ad_a};
  assign cs_v   = {cs_b, cs_a};
  assign wr_v   = {wr_b, wr_a};
  assign rd_v   = {rd_b, rd_a};
  assign drv_v  = {u_b.outs_q.drive, u_a.outs_q.drive};
  assign bus_v[0]   = {8'h00, bus_a};
  assign bus_v[1]   = bus_b;
  assign rdata_v[0] = {8'h00, rdata_a};
  assign rdata_v[1] = rdata_b;

  // kind: 0 = completes with done, 1 = rejected with err, 2 = aborted by reset
  typedef struct {
    int          dut;
    int          kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          busy;   // busy cycles
    int          wa;     // WR low, AD=0, CS=0, bus=addr
    int          wd;     // WR low, AD=1, CS=0, bus=wdata
    int          rdlo;   // RD low
    int          cshi;   // CS high while busy, excluding DONE
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input int kind, input logic [15:0] a,
                      input logic [15:0] w, input logic [15:0] r,
                      input int busy, input int wa, input int wd,
                      input int rdlo, input int cshi);
    exp_t e;
    e.dut = dut; e.kind = kind; e.addr = a; e.wdata = w; e.rdata = r;
    e.busy = busy; e.wa = wa; e.wd = wd; e.rdlo = rdlo; e.cshi = cshi;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int cnt_busy [2];
  int cnt_wa   [2];
  int cnt_wd   [2];
  int cnt_rdlo [2];
  int cnt_cshi [2];
  int bad_drv  [2];
  bit busy_p   [2];
  bit chk_fall [2];

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (chk_fall[d]) begin
          check($sformatf("busy_falls_after_done_%0d", d), 32'(busy_v[d]), 0);
          chk_fall[d] = 1'b0;
        end
        if (busy_v[d] && !busy_p[d]) begin
          cnt_busy[d] = 0; cnt_wa[d] = 0; cnt_wd[d] = 0;
          cnt_rdlo[d] = 0; cnt_cshi[d] = 0;
        end
        if (busy_v[d]) begin
          cnt_busy[d]++;
          if (sb.size() > 0 && sb[0].dut == d) begin
            if (!wr_v[d] && !cs_v[d] && !ad_v[d] && bus_v[d] == sb[0].addr)  cnt_wa[d]++;
            if (!wr_v[d] && !cs_v[d] &&  ad_v[d] && bus_v[d] == sb[0].wdata) cnt_wd[d]++;
            if (!rd_v[d]) cnt_rdlo[d]++;
            if (cs_v[d] && !done_v[d]) cnt_cshi[d]++;
          end
        end
        if (!rd_v[d] && drv_v[d]) bad_drv[d]++;

        if (done_v[d]) begin
          if (sb.size() == 0) begin
            check($sformatf("unexpected_done_%0d", d), 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("done_dut_%0d", d), d, e.dut);
            check($sformatf("done_kind_%0d", d), e.kind, 0);
            check($sformatf("busy_len_%0d", d), cnt_busy[d], e.busy);
            check($sformatf("addr_wr_pulse_%0d", d), cnt_wa[d], e.wa);
            check($sformatf("data_wr_pulse_%0d", d), cnt_wd[d], e.wd);
            check($sformatf("rd_low_cycles_%0d", d), cnt_rdlo[d], e.rdlo);
            check($sformatf("gap_cycles_%0d", d), cnt_cshi[d], e.cshi);
            check($sformatf("rdata_at_done_%0d", d), 32'(rdata_v[d]), 32'(e.rdata));
          end
          chk_fall[d] = 1'b1;
        end

        if (err_v[d]) begin
          if (sb.size() == 0) begin
            check($sformatf("unexpected_err_%0d", d), 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("err_kind_%0d", d), e.kind, 1);
            check($sformatf("err_busy_%0d", d), 32'(busy_v[d]), 0);
          end
        end
        busy_p[d] = busy_v[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_a(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] w);
    int n = 0;
    while (busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_wait_a", 32'(busy_a), 0);
    start_a = 1'b1; op_a = op; addr_a = a; wdata_a = w;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);

    // Reset state, taken while reset is held.
    check("rst_cs",    32'(cs_a), 1);
    check("rst_wr",    32'(wr_a), 1);
    check("rst_rd",    32'(rd_a), 1);
    check("rst_ad",    32'(ad_a), 1);
    check("rst_busy",  32'(busy_a), 0);
    check("rst_done",  32'(done_a), 0);
    check("rst_err",   32'(err_a), 0);
    check("rst_rdata", 32'(rdata_a), 0);
    check("rst_drive", 32'(drv_v[0]), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    // Write 0x5A to 0x21: 15 busy cycles, two 4-cycle WR pulses, 2 gap cycles.
    push(0, 0, 16'h0021, 16'h005A, 16'h0000, 15, 4, 4, 0, 2);
    issue_a(2'b00, 8'h21, 8'h5A);

    // Back-to-back read of 0x23; the RTC model answers 0xC7.
    push(0, 0, 16'h0023, 16'h0000, 16'h00C7, 15, 4, 0, 4, 2);
    issue_a(2'b01, 8'h23, 8'h00);

    // Address-only 0xF0: 7 busy cycles, one WR pulse, rdata keeps 0xC7.
    push(0, 0, 16'h00F0, 16'h0000, 16'h00C7, 7, 4, 0, 0, 0);
    issue_a(2'b10, 8'hF0, 8'h00);

    // Write with a second start mid-transaction, which must be ignored.
    push(0, 0, 16'h0030, 16'h0011, 16'h00C7, 15, 4, 4, 0, 2);
    issue_a(2'b00, 8'h30, 8'h11);
    repeat (5) @(negedge clk);
    start_a = 1'b1; op_a = 2'b01; addr_a = 8'h55;
    @(negedge clk);
    start_a = 1'b0;

    // Illegal op while idle: one err pulse, busy never rises.
    push(0, 1, 16'h0066, 16'h0077, 16'h0000, 0, 0, 0, 0, 0);
    issue_a(2'b11, 8'h66, 8'h77);
    repeat (3) begin
      @(negedge clk);
      check("illegal_busy", 32'(busy_a), 0);
    end

    // Reset during DATA_PULSE of a write: pins return to idle at once.
    push(0, 2, 16'h0044, 16'h0099, 16'h0000, 0, 0, 0, 0, 0);
    issue_a(2'b00, 8'h44, 8'h99);
    n = 0;
    while (!(wr_a == 1'b0 && ad_a == 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_data_pulse", 32'(n < 50), 1);
    rst_a = 1'b1;
    #1;
    check("abort_cs",    32'(cs_a), 1);
    check("abort_wr",    32'(wr_a), 1);
    check("abort_rd",    32'(rd_a), 1);
    check("abort_ad",    32'(ad_a), 1);
    check("abort_busy",  32'(busy_a), 0);
    check("abort_drive", 32'(drv_v[0]), 0);
    check("abort_rdata", 32'(rdata_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", sb.size(), 1);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("abort_entry_kind", e.kind, 2);
    end

    // Instance B: 16-bit read of 0xBEEF, 24 busy cycles.
    push(1, 0, 16'h0123, 16'h0000, 16'hBEEF, 24, 6, 0, 6, 3);
    start_b = 1'b1; op_b = 2'b01; addr_b = 16'h0123; wdata_b = 16'h0000;
    @(negedge clk);
    start_b = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
    check("drive_during_rd_a", bad_drv[0], 0);
    check("drive_during_rd_b", bad_drv[1], 0);
    check("rdata_b_final", 32'(rdata_b), 32'h0000BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
